// File: rtl/spi_master_multi.sv
// SPI master that runs one command/address/data frame per start request.
// Frame width, payload length, SPI clock divider, CPOL/CPHA and target
// chip-select are latched when a frame is accepted. Read payloads are
// captured MSB first and presented right-justified on the done pulse.
module spi_master_multi #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 8,
  parameter  int NUM_CS     = 4,
  parameter  int DIV_WIDTH  = 8,
  localparam int CS_W       = $clog2(NUM_CS),
  localparam int NB_W       = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  read,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [CS_W-1:0]       cs_sel,
  input  logic [NB_W-1:0]       nbytes,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  spi_miso,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  spi_clk,
  output logic [NUM_CS-1:0]     spi_cs_n,
  output logic                  spi_mosi
);

  localparam int FRAME_MAX = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int HC_W      = $clog2(2 * FRAME_MAX);
  localparam int SH_W      = $clog2(DATA_WIDTH + 1);
  // First half-period index that belongs to the payload (bit 1+ADDR_WIDTH).
  localparam logic [HC_W-1:0] PAY_HALF = HC_W'(2 * (1 + ADDR_WIDTH));

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t                 state;
  logic                   read_q, cpol_q, cpha_q;
  logic [DIV_WIDTH-1:0]   div_q, div_cnt;
  logic [HC_W-1:0]        half_cnt, last_half;
  logic [FRAME_MAX-1:0]   tx_shift;
  logic [DATA_WIDTH-1:0]  rx_shift;

  logic [SH_W-1:0]        pay_bits, pay_shift;
  logic [DATA_WIDTH-1:0]  payload;
  logic [FRAME_MAX-1:0]   frame;
  logic [HC_W-1:0]        frame_last_half;
  logic [NUM_CS-1:0]      cs_dec;

  logic                   div_last, edge_fire, leading, drive_now, sample_now;
  logic [HC_W-1:0]        next_half;

  assign div_last = (div_cnt == div_q);

  // Assemble the left-aligned frame and its length from the live inputs.
  always_comb begin
    // NOTE: every combinational output gets a value on every path first, so no latch is inferred.
    pay_bits        = SH_W'({nbytes, 3'b000}) + SH_W'(8);
    pay_shift       = SH_W'(DATA_WIDTH) - pay_bits;
    // Read frames send zeros during the payload; unused high bytes fall off the top.
    payload         = read ? '0 : (write_data << pay_shift);
    frame           = {read, address, payload};
    frame_last_half = HC_W'(2 * (1 + ADDR_WIDTH) - 1) + HC_W'({pay_bits, 1'b0});
    cs_dec          = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
    end
  end

  // Decode the SPI clock edge about to be produced and whether it drives or samples.
  always_comb begin
    edge_fire = 1'b0;
    next_half = '0;
    if (state == SETUP && div_last) begin
      edge_fire = 1'b1;
    end else if (state == SHIFT && div_last && half_cnt != last_half) begin
      edge_fire = 1'b1;
      next_half = half_cnt + 1'b1;
    end
    // Even half-period indices start with a leading edge, odd ones with a trailing edge.
    leading    = ~next_half[0];
    drive_now  = edge_fire && (cpha_q == leading);
    sample_now = edge_fire && (cpha_q != leading) && (next_half >= PAY_HALF);
  end

  // Frame sequencer: state, timing counters, shift registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      read_q    <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      div_q     <= '0;
      div_cnt   <= '0;
      half_cnt  <= '0;
      last_half <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      read_data <= '0;
      spi_clk   <= 1'b0;
      spi_cs_n  <= '1;
      spi_mosi  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE: begin
          spi_clk  <= cpol_q;
          spi_mosi <= 1'b0;
          spi_cs_n <= '1;
          if (start) begin
            read_q    <= read;
            cpol_q    <= cpol;
            cpha_q    <= cpha;
            div_q     <= clk_div;
            last_half <= frame_last_half;
            div_cnt   <= '0;
            half_cnt  <= '0;
            rx_shift  <= '0;
            // CPHA=0 puts the first bit on the wire before the first leading edge.
            tx_shift  <= cpha ? frame : (frame << 1);
            spi_mosi  <= cpha ? 1'b0 : frame[FRAME_MAX-1];
            spi_clk   <= cpol;
            spi_cs_n  <= cs_dec;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (div_last) begin
            div_cnt <= '0;
            spi_clk <= ~cpol_q;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            if (half_cnt == last_half) begin
              state <= HOLD;
            end else begin
              half_cnt <= half_cnt + 1'b1;
              spi_clk  <= ~spi_clk;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (div_last) begin
            div_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            spi_cs_n <= '1;
            spi_mosi <= 1'b0;
            if (read_q) read_data <= rx_shift;
            state    <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (drive_now) begin
        spi_mosi <= tx_shift[FRAME_MAX-1];
        tx_shift <= tx_shift << 1;
      end
      if (sample_now) begin
        rx_shift <= {rx_shift[DATA_WIDTH-2:0], spi_miso};
      end
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: an edge-driven SPI slave model answers
// on MISO and records MOSI, while per-cycle monitors count busy, done and CS.
module tb_spi_master_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, read, cpol, cpha;
  logic [7:0]  clk_div;
  logic [1:0]  cs_sel;
  logic [1:0]  nbytes;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic        spi_miso = 1'b0;
  logic        busy, done;
  logic [31:0] read_data;
  logic        spi_clk;
  logic [3:0]  spi_cs_n;
  logic        spi_mosi;

  int vectors = 0;
  int miscompares = 0;

  // Slave configuration and capture state.
  logic        m_cpol = 1'b0, m_cpha = 1'b0;
  int          m_n = 17;
  logic [63:0] m_bits = '0;
  logic [63:0] mosi_cap = '0;
  int          mosi_cnt = 0;
  int          bidx = 0, leads = 0;
  logic        in_frame = 1'b0, busy_prev = 1'b0, clk_prev = 1'b0;

  // Monitor counters and snapshots.
  int done_cnt = 0, busy_cnt = 0;
  int cs_low_cnt [4] = '{default: 0};
  int b_done, b_busy, b_mosi;
  int b_cs [4];

  spi_master_multi #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_CS(4), .DIV_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .read(read), .cpol(cpol), .cpha(cpha),
    .clk_div(clk_div), .cs_sel(cs_sel), .nbytes(nbytes), .address(address),
    .write_data(write_data), .spi_miso(spi_miso), .busy(busy), .done(done),
    .read_data(read_data), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi)
  );

  always #5 clk = ~clk;

  // SPI slave: presents MISO bits and captures MOSI on the mode's edges.
  always @(spi_clk or busy) begin
    if (busy === 1'b1 && busy_prev !== 1'b1) begin
      in_frame = 1'b1;
      leads    = 0;
      bidx     = 0;
      if (!m_cpha) begin
        spi_miso = m_bits[m_n-1];
        bidx     = 1;
      end
    end else if (busy !== 1'b1 && busy_prev === 1'b1) begin
      in_frame = 1'b0;
    end
    busy_prev = busy;
    if (spi_clk !== clk_prev) begin
      clk_prev = spi_clk;
      if (in_frame) begin
        if (spi_clk !== m_cpol) begin
          leads++;
          if (m_cpha) begin
            spi_miso = (bidx < m_n) ? m_bits[m_n-1-bidx] : 1'b0;
            bidx++;
          end else begin
            mosi_cap = {mosi_cap[62:0], spi_mosi};
            mosi_cnt++;
          end
        end else if (leads > 0) begin
          if (m_cpha) begin
            mosi_cap = {mosi_cap[62:0], spi_mosi};
            mosi_cnt++;
          end else begin
            spi_miso = (bidx < m_n) ? m_bits[m_n-1-bidx] : 1'b0;
            bidx++;
          end
        end
      end
    end
  end

  // Per-cycle monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
    for (int i = 0; i < 4; i++) if (spi_cs_n[i] === 1'b0) cs_low_cnt[i]++;
  end

  task automatic snap();
    b_done = done_cnt;
    b_busy = busy_cnt;
    b_mosi = mosi_cnt;
    for (int i = 0; i < 4; i++) b_cs[i] = cs_low_cnt[i];
  endtask

  // Load the slave with its reply: ones during cmd/addr, then the payload.
  task automatic set_slave(input logic cp, input logic ch, input logic [1:0] nb,
                           input logic [31:0] sd);
    m_cpol = cp;
    m_cpha = ch;
    m_n    = 9 + 8 * (int'(nb) + 1);
    m_bits = '0;
    for (int i = 0; i < 9; i++) m_bits[m_n-1-i] = 1'b1;
    for (int i = 0; i < 8 * (int'(nb) + 1); i++) m_bits[i] = sd[i];
  endtask

  task automatic drive_frame(input logic rd, input logic cp, input logic ch,
                             input logic [7:0] dv, input logic [1:0] cs,
                             input logic [1:0] nb, input logic [7:0] ad,
                             input logic [31:0] wd, input logic [31:0] sd);
    set_slave(cp, ch, nb, sd);
    @(posedge clk); #1;
    read = rd; cpol = cp; cpha = ch; clk_div = dv; cs_sel = cs;
    nbytes = nb; address = ad; write_data = wd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; read = 1'b0; cpol = 1'b0; cpha = 1'b0;
    clk_div = '0; cs_sel = '0; nbytes = '0; address = '0; write_data = '0;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done); end
    vectors++; if (spi_cs_n !== 4'hF) begin miscompares++; $display("FAIL rst_cs got %h want f", spi_cs_n); end
    vectors++; if (spi_clk !== 1'b0) begin miscompares++; $display("FAIL rst_sclk got %b want 0", spi_clk); end
    vectors++; if (spi_mosi !== 1'b0) begin miscompares++; $display("FAIL rst_mosi got %b want 0", spi_mosi); end
    vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h want 0", read_data); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0_write();
    logic seen;
    snap();
    drive_frame(1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 2'd0, 8'hA5, 32'hFFFF_FF3C, 32'h0000_00FF);
    wait_done(1000, seen);
    repeat (3) @(negedge clk);
    vectors++; if (!seen) begin miscompares++; $display("FAIL m0_done_timeout got 0 want 1"); end
    vectors++; if (done_cnt - b_done != 1) begin miscompares++; $display("FAIL m0_done_count got %0d want 1", done_cnt - b_done); end
    vectors++; if (cs_low_cnt[0] - b_cs[0] != 72) begin miscompares++; $display("FAIL m0_cs0_low got %0d want 72", cs_low_cnt[0] - b_cs[0]); end
    vectors++; if (busy_cnt - b_busy != 72) begin miscompares++; $display("FAIL m0_busy got %0d want 72", busy_cnt - b_busy); end
    vectors++; if ((cs_low_cnt[1] - b_cs[1]) + (cs_low_cnt[2] - b_cs[2]) + (cs_low_cnt[3] - b_cs[3]) != 0)
      begin miscompares++; $display("FAIL m0_other_cs got %0d want 0", (cs_low_cnt[1] - b_cs[1]) + (cs_low_cnt[2] - b_cs[2]) + (cs_low_cnt[3] - b_cs[3])); end
    vectors++; if (mosi_cnt - b_mosi != 17) begin miscompares++; $display("FAIL m0_mosi_bits got %0d want 17", mosi_cnt - b_mosi); end
    vectors++; if (mosi_cap[16:0] !== 17'h0A53C) begin miscompares++; $display("FAIL m0_mosi got %h want 0a53c", mosi_cap[16:0]); end
    vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL m0_rdata_kept got %h want 0", read_data); end
  endtask

  task automatic test_mode3_read();
    logic seen;
    snap();
    drive_frame(1'b1, 1'b1, 1'b1, 8'd1, 2'd2, 2'd3, 8'h5A, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    wait_done(1000, seen);
    repeat (3) @(negedge clk);
    vectors++; if (!seen) begin miscompares++; $display("FAIL m3_done_timeout got 0 want 1"); end
    vectors++; if (read_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL m3_rdata got %h want deadbeef", read_data); end
    vectors++; if (spi_clk !== 1'b1) begin miscompares++; $display("FAIL m3_sclk_idle got %b want 1", spi_clk); end
    vectors++; if (cs_low_cnt[2] - b_cs[2] != 168) begin miscompares++; $display("FAIL m3_cs2_low got %0d want 168", cs_low_cnt[2] - b_cs[2]); end
    vectors++; if ((cs_low_cnt[0] - b_cs[0]) + (cs_low_cnt[1] - b_cs[1]) + (cs_low_cnt[3] - b_cs[3]) != 0)
      begin miscompares++; $display("FAIL m3_other_cs got %0d want 0", (cs_low_cnt[0] - b_cs[0]) + (cs_low_cnt[1] - b_cs[1]) + (cs_low_cnt[3] - b_cs[3])); end
    vectors++; if (mosi_cnt - b_mosi != 41) begin miscompares++; $display("FAIL m3_mosi_bits got %0d want 41", mosi_cnt - b_mosi); end
    vectors++; if (mosi_cap[40:0] !== {1'b1, 8'h5A, 32'h0}) begin miscompares++; $display("FAIL m3_mosi got %h want %h", mosi_cap[40:0], {1'b1, 8'h5A, 32'h0}); end
    vectors++; if (done_cnt - b_done != 1) begin miscompares++; $display("FAIL m3_done_count got %0d want 1", done_cnt - b_done); end
  endtask

  task automatic test_mode1_read();
    logic seen;
    snap();
    drive_frame(1'b1, 1'b0, 1'b1, 8'd0, 2'd3, 2'd1, 8'hE7, 32'h0000_FFFF, 32'hABCD_1234);
    wait_done(1000, seen);
    repeat (3) @(negedge clk);
    vectors++; if (!seen) begin miscompares++; $display("FAIL m1_done_timeout got 0 want 1"); end
    vectors++; if (read_data !== 32'h0000_1234) begin miscompares++; $display("FAIL m1_rdata got %h want 00001234", read_data); end
    vectors++; if (busy_cnt - b_busy != 52) begin miscompares++; $display("FAIL m1_busy got %0d want 52", busy_cnt - b_busy); end
    vectors++; if (cs_low_cnt[3] - b_cs[3] != 52) begin miscompares++; $display("FAIL m1_cs3_low got %0d want 52", cs_low_cnt[3] - b_cs[3]); end
    vectors++; if (mosi_cap[24:0] !== 25'h1E70000) begin miscompares++; $display("FAIL m1_mosi got %h want 1e70000", mosi_cap[24:0]); end
  endtask

  task automatic test_start_ignored();
    logic seen;
    snap();
    drive_frame(1'b0, 1'b0, 1'b0, 8'd1, 2'd1, 2'd0, 8'h11, 32'h0000_0077, 32'h0000_0000);
    repeat (20) @(posedge clk);
    #1;
    address = 8'h99; cs_sel = 2'd0; read = 1'b1; write_data = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1000, seen);
    repeat (40) @(negedge clk);
    vectors++; if (!seen) begin miscompares++; $display("FAIL ign_done_timeout got 0 want 1"); end
    vectors++; if (done_cnt - b_done != 1) begin miscompares++; $display("FAIL ign_done_count got %0d want 1", done_cnt - b_done); end
    vectors++; if (busy_cnt - b_busy != 72) begin miscompares++; $display("FAIL ign_busy got %0d want 72", busy_cnt - b_busy); end
    vectors++; if (cs_low_cnt[1] - b_cs[1] != 72) begin miscompares++; $display("FAIL ign_cs1_low got %0d want 72", cs_low_cnt[1] - b_cs[1]); end
    vectors++; if (cs_low_cnt[0] - b_cs[0] != 0) begin miscompares++; $display("FAIL ign_cs0_low got %0d want 0", cs_low_cnt[0] - b_cs[0]); end
    vectors++; if (mosi_cap[16:0] !== 17'h01177) begin miscompares++; $display("FAIL ign_mosi got %h want 01177", mosi_cap[16:0]); end
    vectors++; if (read_data !== 32'h0000_1234) begin miscompares++; $display("FAIL ign_rdata_kept got %h want 00001234", read_data); end
  endtask

  task automatic test_reset_mid_frame();
    drive_frame(1'b1, 1'b1, 1'b1, 8'd3, 2'd3, 2'd3, 8'h42, 32'h0, 32'hCAFE_F00D);
    repeat (40) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (spi_cs_n !== 4'hF) begin miscompares++; $display("FAIL mid_rst_cs got %h want f", spi_cs_n); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    vectors++; if (spi_clk !== 1'b0) begin miscompares++; $display("FAIL mid_rst_sclk got %b want 0", spi_clk); end
    vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL mid_rst_rdata got %h want 0", read_data); end
    vectors++; if (spi_mosi !== 1'b0) begin miscompares++; $display("FAIL mid_rst_mosi got %b want 0", spi_mosi); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode2_read();
    logic seen;
    snap();
    drive_frame(1'b1, 1'b1, 1'b0, 8'd2, 2'd0, 2'd1, 8'h3C, 32'h0, 32'hFFFF_1234);
    wait_done(1000, seen);
    repeat (3) @(negedge clk);
    vectors++; if (!seen) begin miscompares++; $display("FAIL m2_done_timeout got 0 want 1"); end
    vectors++; if (read_data !== 32'h0000_1234) begin miscompares++; $display("FAIL m2_rdata got %h want 00001234", read_data); end
    vectors++; if (busy_cnt - b_busy != 156) begin miscompares++; $display("FAIL m2_busy got %0d want 156", busy_cnt - b_busy); end
    vectors++; if (cs_low_cnt[0] - b_cs[0] != 156) begin miscompares++; $display("FAIL m2_cs0_low got %0d want 156", cs_low_cnt[0] - b_cs[0]); end
    vectors++; if (mosi_cap[24:0] !== 25'h13C0000) begin miscompares++; $display("FAIL m2_mosi got %h want 13c0000", mosi_cap[24:0]); end
    vectors++; if (spi_clk !== 1'b1) begin miscompares++; $display("FAIL m2_sclk_idle got %b want 1", spi_clk); end
    vectors++; if (done_cnt - b_done != 1) begin miscompares++; $display("FAIL m2_done_count got %0d want 1", done_cnt - b_done); end
  endtask

  task automatic test_back_to_back();
    logic seen;
    snap();
    set_slave(1'b0, 1'b0, 2'd0, 32'h0);
    @(posedge clk); #1;
    read = 1'b0; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; cs_sel = 2'd0;
    nbytes = 2'd0; address = 8'hC3; write_data = 32'h0000_005A; start = 1'b1;
    wait_done(1000, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL b2b_done1_timeout got 0 want 1"); end
    vectors++; if (spi_cs_n[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_cs_gap got %b want 1", spi_cs_n[0]); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_gap got %b want 0", busy); end
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_restart_busy got %b want 1", busy); end
    vectors++; if (spi_cs_n[0] !== 1'b0) begin miscompares++; $display("FAIL b2b_restart_cs got %b want 0", spi_cs_n[0]); end
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1000, seen);
    repeat (5) @(negedge clk);
    vectors++; if (!seen) begin miscompares++; $display("FAIL b2b_done2_timeout got 0 want 1"); end
    vectors++; if (done_cnt - b_done != 2) begin miscompares++; $display("FAIL b2b_done_count got %0d want 2", done_cnt - b_done); end
    vectors++; if (busy_cnt - b_busy != 72) begin miscompares++; $display("FAIL b2b_busy got %0d want 72", busy_cnt - b_busy); end
    vectors++; if (cs_low_cnt[0] - b_cs[0] != 72) begin miscompares++; $display("FAIL b2b_cs0_low got %0d want 72", cs_low_cnt[0] - b_cs[0]); end
    vectors++; if (mosi_cap[33:0] !== {2{17'h0C35A}}) begin miscompares++; $display("FAIL b2b_mosi got %h want %h", mosi_cap[33:0], {2{17'h0C35A}}); end
  endtask

  initial begin
    test_reset();
    test_mode0_write();
    test_mode3_read();
    test_mode1_read();
    test_start_ignored();
    test_reset_mid_frame();
    test_mode2_read();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
